keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad on the divided system clock (~183 Hz) from the clock divider.
- Drives one column low at a time, samples the active-low rows, and debounces presses and releases.
- Emits a one-cycle strobe with the 4-bit hex code for each new debounced press.
- Downstream display/digit-shift logic consumes `key_valid`/`key_code` on the same clock.

Parameters:
- DEBOUNCE_CYCLES, 8: consecutive stable clk cycles required to accept a press or a release (~44 ms at 183 Hz); legal range 2..255.
- DWELL_CYCLES, 3: clk cycles each column stays driven in SCAN before its rows are sampled; must be >= 3 to cover the synchronizer.

Ports:
- clk  input  1  divided slow clock from the clock divider; all logic on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- rows  input  4  raw keypad rows, active-low (external pull-ups), asynchronous.
- cols  output  4  column drive, active-low one-hot.
- key_code  output  4  hex value of the last accepted key; holds between presses.
- key_valid  output  1  single-cycle pulse when a new press is accepted.
- key_held  output  1  high from acceptance until release is debounced.

Behaviour:
- Reset (reset==0 at posedge):
  - state=SCAN, col_idx=0, cols=4'b1110.
  - key_code=4'h0, key_valid=0, key_held=0.
  - All counters=0; both synchronizer stages=4'b1111.
  - Reset mid-press aborts with no pulse.
- Synchronizer: rows pass through two flops (rows_s). The FSM uses only rows_s.
- cols = ~(4'b0001 << col_idx). cols is registered and changes only on col_idx updates.
- Key map, [row][col]:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- SCAN:
  - dwell counter increments each cycle.
  - On the cycle dwell==DWELL_CYCLES-1, rows_s is sampled:
    - If rows_s==4'b1111: col_idx advances (3 wraps to 0), dwell=0.
    - Otherwise: latch row_idx = lowest-index low bit of rows_s (multi-row press resolves to the lowest row). Keep col_idx, deb=1, go DEBOUNCE.
- DEBOUNCE:
  - Each cycle: if rows_s[row_idx]==0, deb++; else go SCAN with dwell=0 on the same col_idx, and no pulse.
  - When deb reaches DEBOUNCE_CYCLES: key_code=map(row_idx,col_idx), key_valid=1 for exactly that cycle, key_held=1, go HELD.
- HELD:
  - Column stays driven.
  - Other keys are ignored: other columns are undriven; other rows in this column are masked.
  - rows_s[row_idx]==1 → deb=1, go RELEASE.
- RELEASE:
  - rows_s[row_idx]==1 → deb++.
  - rows_s[row_idx]==0 (bounce) → back to HELD with no new pulse.
  - deb reaches DEBOUNCE_CYCLES → key_held=0, col_idx=0, dwell=0, go SCAN.
- key_valid is 0 in every state/cycle except the acceptance cycle.
- key_code changes only on acceptance.
- Press-to-pulse latency from the raw row edge, column already driven and key stable:
  - 2 sync cycles + remaining dwell + DEBOUNCE_CYCLES.
  - Worst case: 2 + DWELL_CYCLES + DEBOUNCE_CYCLES cycles past the first sample opportunity.
- Held key never repeats. A new press after release yields exactly one new pulse.
- All counters are saturating-safe: deb is compared with == and never wraps.

Test Plan:
- Idle, no keys, 40 cycles after reset:
  - cols cycles 1110→1101→1011→0111→1110, each held DWELL_CYCLES=3 cycles.
  - key_valid never 1; key_code==0.
- Press key "6" (row1/col2), held clean for 30 cycles then released:
  - Exactly one key_valid pulse with key_code==4'h6.
  - key_held high until 8 cycles after the release is seen on rows_s.
  - cols frozen at 1011 while held.
- Bounce on press: row1/col0 low 3 cycles, high 1, then low stable:
  - No pulse during the bounce.
  - Single pulse with key_code==4'h4 after 8 stable cycles.
- Bounce on release of "D" (row3/col3): release pattern high2/low1/high stable:
  - No second pulse.
  - key_held falls 8 cycles after the final rising edge.
- Simultaneous keys "1" (r0c0) and "7" (r2c0) pressed together:
  - key_code==4'h1, one pulse.
  - Pressing "9" (r2c2) while "1" is held gives no pulse.
  - After full release, pressing "9" gives key_code==4'h9.
- Assert reset=0 for one cycle mid-DEBOUNCE and mid-HELD:
  - Next cycle: cols==1110, key_held==0, key_valid==0, key_code==0.
  - A still-pressed key is re-detected and produces exactly one fresh pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scan, debounce and key strobe.
// Runs on the divided slow clock; rows are active-low with pull-ups.
module keypad_scanner #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int DWELL_CYCLES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);
  localparam logic [7:0] DEB_DONE   = 8'(DEBOUNCE_CYCLES);

  state_t     state, state_n;
  logic [1:0] col_idx, col_n;
  logic [1:0] row_idx, row_n;
  logic [7:0] dwell, dwell_n;
  logic [7:0] deb, deb_n;
  logic [3:0] rows_m, rows_s;
  logic [3:0] code_n;
  logic       valid_n;
  logic       held_n;
  logic       row_low;

  function automatic logic [3:0] key_map(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    k = 4'h0;
    unique case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      4'hF: k = 4'hD;
    endcase
    return k;
  endfunction

  // Only the latched row matters once a key is found.
  assign row_low = ~rows_s[row_idx];

  always_comb begin
    state_n = state;
    col_n   = col_idx;
    row_n   = row_idx;
    dwell_n = dwell;
    deb_n   = deb;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
    unique case (state)
      SCAN: begin
        dwell_n = dwell + 8'd1;
        if (dwell == DWELL_LAST) begin
          dwell_n = 8'd0;
          if (rows_s == 4'b1111) begin
            col_n = col_idx + 2'd1;
          end else begin
            priority case (1'b1)
              !rows_s[0]: row_n = 2'd0;
              !rows_s[1]: row_n = 2'd1;
              !rows_s[2]: row_n = 2'd2;
              default:    row_n = 2'd3;
            endcase
            deb_n   = 8'd1;
            state_n = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (row_low) begin
          deb_n = deb + 8'd1;
          if (deb_n == DEB_DONE) begin
            code_n  = key_map(row_idx, col_idx);
            valid_n = 1'b1;
            held_n  = 1'b1;
            state_n = HELD;
          end
        end else begin
          dwell_n = 8'd0;
          state_n = SCAN;
        end
      end
      HELD: begin
        if (!row_low) begin
          deb_n   = 8'd1;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (!row_low) begin
          deb_n = deb + 8'd1;
          if (deb_n == DEB_DONE) begin
            held_n  = 1'b0;
            col_n   = 2'd0;
            dwell_n = 8'd0;
            state_n = SCAN;
          end
        end else begin
          state_n = HELD;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      dwell     <= 8'd0;
      deb       <= 8'd0;
      rows_m    <= 4'b1111;
      rows_s    <= 4'b1111;
      cols      <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      rows_m    <= rows;
      rows_s    <= rows_m;
      state     <= state_n;
      col_idx   <= col_n;
      row_idx   <= row_n;
      dwell     <= dwell_n;
      deb       <= deb_n;
      cols      <= ~(4'b0001 << col_n);
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model plus scoreboard of expected codes.
// Each scenario task drives presses and checks outputs inline.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  logic [3:0]  exp_q[$];
  int          tests;
  int          fails;
  int          pulse_cnt;

  keypad_scanner #(
    .DEBOUNCE_CYCLES(8),
    .DWELL_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rows(rows),
    .cols(cols),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a pressed key shorts its row to its column.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      logic [3:0] e;
      pulse_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse code=%h t=%0t",
                 key_code, $time);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e) begin
          fails++;
          $display("FAIL pulse_code got=%h exp=%h t=%0t",
                   key_code, e, $time);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (key_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_release(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (!key_held) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    pressed = '0;
    tick(3);
    tests += 4;
    if (cols !== 4'b1110) begin
      fails++;
      $display("FAIL rst_cols got=%b exp=1110", cols);
    end
    if (key_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid got=%b exp=0", key_valid);
    end
    if (key_held !== 1'b0) begin
      fails++;
      $display("FAIL rst_held got=%b exp=0", key_held);
    end
    if (key_code !== 4'h0) begin
      fails++;
      $display("FAIL rst_code got=%h exp=0", key_code);
    end
    reset = 1'b1;
  endtask

  task automatic test_idle;
    logic [3:0] e;
    for (int i = 0; i < 40; i++) begin
      e = 4'b1111;
      e[2'((i / 3) % 4)] = 1'b0;
      tests += 2;
      if (cols !== e) begin
        fails++;
        $display("FAIL idle_cols i=%0d got=%b exp=%b", i, cols, e);
      end
      if (key_valid !== 1'b0) begin
        fails++;
        $display("FAIL idle_valid i=%0d got=1 exp=0", i);
      end
      tick(1);
    end
    tests++;
    if (key_code !== 4'h0) begin
      fails++;
      $display("FAIL idle_code got=%h exp=0", key_code);
    end
  endtask

  task automatic test_press_6;
    bit ok;
    int p0;
    p0 = pulse_cnt;
    pressed[6] = 1'b1;
    exp_q.push_back(4'h6);
    wait_valid(40, ok);
    tests += 2;
    if (!ok) begin
      fails++;
      $display("FAIL p6_timeout got=none exp=pulse");
    end
    if (key_held !== 1'b1) begin
      fails++;
      $display("FAIL p6_held got=%b exp=1", key_held);
    end
    for (int i = 0; i < 30; i++) begin
      tick(1);
      tests++;
      if (cols !== 4'b1011 || key_held !== 1'b1) begin
        fails++;
        $display("FAIL p6_frozen i=%0d cols=%b held=%b exp=1011/1",
                 i, cols, key_held);
      end
    end
    tests++;
    if (pulse_cnt - p0 !== 1) begin
      fails++;
      $display("FAIL p6_pulses got=%0d exp=1", pulse_cnt - p0);
    end
    pressed[6] = 1'b0;
    tick(9);
    tests++;
    if (key_held !== 1'b1) begin
      fails++;
      $display("FAIL p6_held_early got=%b exp=1", key_held);
    end
    tick(1);
    tests += 3;
    if (key_held !== 1'b0) begin
      fails++;
      $display("FAIL p6_held_fall got=%b exp=0", key_held);
    end
    if (cols !== 4'b1110) begin
      fails++;
      $display("FAIL p6_cols_rel got=%b exp=1110", cols);
    end
    if (key_code !== 4'h6) begin
      fails++;
      $display("FAIL p6_code_hold got=%h exp=6", key_code);
    end
  endtask

  // Starts on the cycle column 0 is freshly driven.
  task automatic test_press_bounce;
    bit ok;
    int p0;
    int bad;
    p0 = pulse_cnt;
    bad = 0;
    exp_q.push_back(4'h4);
    pressed[4] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 4) pressed[4] = 1'b0;
      if (i == 5) pressed[4] = 1'b1;
      tick(1);
      if (i < 16 && key_valid) bad++;
    end
    tests += 2;
    if (bad != 0) begin
      fails++;
      $display("FAIL pb_early got=%0d exp=0 pulses", bad);
    end
    if (key_valid !== 1'b1) begin
      fails++;
      $display("FAIL pb_latency got=%b exp=1", key_valid);
    end
    tick(10);
    tests++;
    if (pulse_cnt - p0 !== 1) begin
      fails++;
      $display("FAIL pb_pulses got=%0d exp=1", pulse_cnt - p0);
    end
    pressed[4] = 1'b0;
    wait_release(30, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL pb_release got=held exp=released");
    end
  endtask

  task automatic test_release_bounce;
    bit ok;
    int p0;
    int drop;
    p0 = pulse_cnt;
    drop = 0;
    pressed[15] = 1'b1;
    exp_q.push_back(4'hD);
    wait_valid(40, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rb_timeout got=none exp=pulse");
    end
    tick(5);
    pressed[15] = 1'b0;
    tick(2);
    if (!key_held) drop++;
    pressed[15] = 1'b1;
    tick(1);
    if (!key_held) drop++;
    pressed[15] = 1'b0;
    tick(9);
    if (!key_held) drop++;
    tests += 3;
    if (drop != 0) begin
      fails++;
      $display("FAIL rb_held_early got=%0d drops exp=0", drop);
    end
    tick(1);
    if (key_held !== 1'b0) begin
      fails++;
      $display("FAIL rb_held_fall got=%b exp=0", key_held);
    end
    if (pulse_cnt - p0 !== 1) begin
      fails++;
      $display("FAIL rb_pulses got=%0d exp=1", pulse_cnt - p0);
    end
  endtask

  task automatic test_multi_key;
    bit ok;
    int p0;
    p0 = pulse_cnt;
    pressed[0] = 1'b1;
    pressed[8] = 1'b1;
    exp_q.push_back(4'h1);
    wait_valid(40, ok);
    tests += 2;
    if (!ok) begin
      fails++;
      $display("FAIL mk_timeout got=none exp=pulse");
    end
    if (key_code !== 4'h1) begin
      fails++;
      $display("FAIL mk_code got=%h exp=1", key_code);
    end
    pressed[10] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      tests++;
      if (key_valid !== 1'b0 || cols !== 4'b1110) begin
        fails++;
        $display("FAIL mk_masked i=%0d valid=%b cols=%b exp=0/1110",
                 i, key_valid, cols);
      end
    end
    pressed = '0;
    wait_release(30, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL mk_release got=held exp=released");
    end
    pressed[10] = 1'b1;
    exp_q.push_back(4'h9);
    wait_valid(40, ok);
    tests += 2;
    if (!ok) begin
      fails++;
      $display("FAIL mk9_timeout got=none exp=pulse");
    end
    if (key_code !== 4'h9) begin
      fails++;
      $display("FAIL mk9_code got=%h exp=9", key_code);
    end
    pressed = '0;
    wait_release(30, ok);
    tests += 2;
    if (!ok) begin
      fails++;
      $display("FAIL mk9_release got=held exp=released");
    end
    if (pulse_cnt - p0 !== 2) begin
      fails++;
      $display("FAIL mk_pulses got=%0d exp=2", pulse_cnt - p0);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int p0;
    p0 = pulse_cnt;
    pressed[5] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (cols == 4'b1101) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rm_col1 got=%b exp=1101", cols);
    end
    tick(5);
    for (int k = 0; k < 2; k++) begin
      reset = 1'b0;
      tick(1);
      tests += 4;
      if (cols !== 4'b1110) begin
        fails++;
        $display("FAIL rm%0d_cols got=%b exp=1110", k, cols);
      end
      if (key_held !== 1'b0) begin
        fails++;
        $display("FAIL rm%0d_held got=%b exp=0", k, key_held);
      end
      if (key_valid !== 1'b0) begin
        fails++;
        $display("FAIL rm%0d_valid got=%b exp=0", k, key_valid);
      end
      if (key_code !== 4'h0) begin
        fails++;
        $display("FAIL rm%0d_code got=%h exp=0", k, key_code);
      end
      reset = 1'b1;
      exp_q.push_back(4'h5);
      wait_valid(40, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL rm%0d_redetect got=none exp=pulse", k);
      end
      tick(5);
    end
    pressed = '0;
    wait_release(30, ok);
    tests += 2;
    if (!ok) begin
      fails++;
      $display("FAIL rm_release got=held exp=released");
    end
    if (pulse_cnt - p0 !== 2) begin
      fails++;
      $display("FAIL rm_pulses got=%0d exp=2", pulse_cnt - p0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    pulse_cnt = 0;
    reset = 1'b0;
    pressed = '0;
    test_reset();
    test_idle();
    test_press_6();
    test_press_bounce();
    test_release_bounce();
    test_multi_key();
    test_reset_mid();
    tick(2);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
